// File: rtl/sram_controller_if.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | sram_controller_if : MEM-stage request/response bus of the SRAM sequencer |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
interface sram_controller_if;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;

  modport master (
    output wr_en, rd_en, address, write_data,
    input  read_data, ready
  );

  modport slave (
    input  wr_en, rd_en, address, write_data,
    output read_data, ready
  );
endinterface
`default_nettype wire

// File: rtl/sram_controller.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | sram_controller : splits 32-bit MEM accesses into two 16-bit async SRAM   |
// | cycles padded to a fixed latency; ready low stalls the pipeline.         |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module sram_controller #(
  parameter int          ACCESS_CYCLES = 6,
  parameter logic [31:0] BASE_ADDR     = 32'd1024
) (
  input  wire logic        clk,
  input  wire logic        rst,
  sram_controller_if.slave mem_bus,
  inout  wire       [15:0] SRAM_DQ,
  output logic      [17:0] SRAM_ADDR,
  output logic             SRAM_WE_N,
  output logic             SRAM_UB_N,
  output logic             SRAM_LB_N,
  output logic             SRAM_CE_N,
  output logic             SRAM_OE_N
);

  localparam int CW        = 16;
  localparam int WAIT_LAST = (ACCESS_CYCLES > 4) ? ACCESS_CYCLES - 5 : 0;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LO   = 3'd1,
    S_HI   = 3'd2,
    S_WAIT = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic            r_op_wr;
  logic [16:0]     r_idx;
  logic [15:0]     r_wdata_hi;
  logic [31:0]     r_rdata;
  logic [17:0]     r_addr;
  logic            r_we_n;
  logic            r_dq_oe;
  logic [15:0]     r_dq_out;

  logic            w_req;
  logic [16:0]     w_idx;
  logic            w_ready;

  assign w_req = mem_bus.rd_en | mem_bus.wr_en;
  // Word index relative to the SRAM window; byte-offset bits drop out in the shift.
  assign w_idx = 17'((mem_bus.address - BASE_ADDR) >> 2);

  always_comb begin
    w_ready = 1'b0;
    if (r_state == S_IDLE)      w_ready = ~w_req;
    else if (r_state == S_DONE) w_ready = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_op_wr    <= 1'b0;
      r_idx      <= '0;
      r_wdata_hi <= '0;
      r_rdata    <= '0;
      r_addr     <= '0;
      r_we_n     <= 1'b1;
      r_dq_oe    <= 1'b0;
      r_dq_out   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            // Pin values for the low half are set up here so they are valid throughout LO.
            r_op_wr    <= mem_bus.wr_en;
            r_idx      <= w_idx;
            r_wdata_hi <= mem_bus.write_data[31:16];
            r_addr     <= {w_idx, 1'b0};
            r_we_n     <= ~mem_bus.wr_en;
            r_dq_oe    <= mem_bus.wr_en;
            r_dq_out   <= mem_bus.write_data[15:0];
            r_state    <= S_LO;
          end
        end
        S_LO: begin
          if (!r_op_wr) r_rdata[15:0] <= SRAM_DQ;
          r_addr   <= {r_idx, 1'b1};
          r_dq_out <= r_wdata_hi;
          r_state  <= S_HI;
        end
        S_HI: begin
          if (!r_op_wr) r_rdata[31:16] <= SRAM_DQ;
          r_we_n  <= 1'b1;
          r_dq_oe <= 1'b0;
          r_cnt   <= '0;
          r_state <= (ACCESS_CYCLES == 4) ? S_DONE : S_WAIT;
        end
        S_WAIT: begin
          if (r_cnt == CW'(WAIT_LAST)) r_state <= S_DONE;
          else                         r_cnt   <= r_cnt + 16'd1;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign SRAM_DQ           = r_dq_oe ? r_dq_out : 16'hzzzz;
  assign SRAM_ADDR         = r_addr;
  assign SRAM_WE_N         = r_we_n;
  assign SRAM_UB_N         = 1'b0;
  assign SRAM_LB_N         = 1'b0;
  assign SRAM_CE_N         = 1'b0;
  assign SRAM_OE_N         = 1'b0;
  assign mem_bus.read_data = r_rdata;
  assign mem_bus.ready     = w_ready;

endmodule
`default_nettype wire

// File: tb/tb_sram_controller.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_sram_controller : directed bench with a behavioural 16-bit SRAM model  |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_sram_controller;
  logic        clk;
  logic        rst;
  wire  [15:0] sram_dq;
  logic [17:0] sram_addr;
  logic        sram_we_n, sram_ub_n, sram_lb_n, sram_ce_n, sram_oe_n;

  sram_controller_if bus();

  sram_controller #(.ACCESS_CYCLES(6), .BASE_ADDR(32'd1024)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_bus   (bus),
    .SRAM_DQ   (sram_dq),
    .SRAM_ADDR (sram_addr),
    .SRAM_WE_N (sram_we_n),
    .SRAM_UB_N (sram_ub_n),
    .SRAM_LB_N (sram_lb_n),
    .SRAM_CE_N (sram_ce_n),
    .SRAM_OE_N (sram_oe_n)
  );

  // SRAM model: drives stored data (or a 0 probe) only while the DUT is not writing.
  logic [15:0] mem [0:262143];
  logic        drive_en;
  logic        probe;
  logic [15:0] tb_val;
  assign tb_val  = probe ? 16'h0000 : mem[sram_addr];
  assign sram_dq = (drive_en && sram_we_n) ? tb_val : 16'hzzzz;

  always @(posedge clk) if (!sram_we_n) mem[sram_addr] <= sram_dq;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_err;

  logic        t_ready [0:15];
  logic        t_we    [0:15];
  logic [17:0] t_addr  [0:15];
  logic [15:0] t_dq    [0:15];
  logic [31:0] t_rd    [0:15];

  task automatic start_req(input logic wr, input logic rd, input logic [31:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    bus.wr_en = wr; bus.rd_en = rd; bus.address = a; bus.write_data = d;
  endtask

  task automatic drop_req();
    @(posedge clk); #1;
    bus.wr_en = 1'b0; bus.rd_en = 1'b0;
  endtask

  task automatic record(input int first, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      t_ready[first+i] = bus.ready;
      t_we[first+i]    = sram_we_n;
      t_addr[first+i]  = sram_addr;
      t_dq[first+i]    = sram_dq;
      t_rd[first+i]    = bus.read_data;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.address = '0; bus.write_data = '0;
    drive_en = 1'b0; probe = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.read_data !== 32'h0) begin n_err++; $display("FAIL reset read_data: got %h want 00000000", bus.read_data); end
    n_cmp++; if (bus.ready !== 1'b1) begin n_err++; $display("FAIL reset ready: got %b want 1", bus.ready); end
    n_cmp++; if (sram_we_n !== 1'b1) begin n_err++; $display("FAIL reset we_n: got %b want 1", sram_we_n); end
    n_cmp++; if (sram_addr !== 18'h0) begin n_err++; $display("FAIL reset sram_addr: got %h want 0", sram_addr); end
  endtask

  task automatic test_idle();
    drive_en = 1'b1; probe = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++; if (bus.ready !== 1'b1) begin n_err++; $display("FAIL idle ready[%0d]: got %b want 1", i, bus.ready); end
      n_cmp++; if (sram_we_n !== 1'b1) begin n_err++; $display("FAIL idle we_n[%0d]: got %b want 1", i, sram_we_n); end
      n_cmp++; if (sram_dq !== 16'h0000) begin n_err++; $display("FAIL idle dq_released[%0d]: got %h want 0000 probe", i, sram_dq); end
    end
    drive_en = 1'b0; probe = 1'b0;
  endtask

  task automatic test_write();
    logic [0:5] e_rdy;
    logic [0:5] e_we;
    e_rdy = 6'b000001; e_we = 6'b100111;
    start_req(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF);
    record(0, 6);
    drop_req();
    for (int i = 0; i < 6; i++) begin
      n_cmp++; if (t_ready[i] !== e_rdy[i]) begin n_err++; $display("FAIL write ready[%0d]: got %b want %b", i, t_ready[i], e_rdy[i]); end
      n_cmp++; if (t_we[i] !== e_we[i]) begin n_err++; $display("FAIL write we_n[%0d]: got %b want %b", i, t_we[i], e_we[i]); end
    end
    n_cmp++; if (t_addr[1] !== 18'h0) begin n_err++; $display("FAIL write addr_lo: got %h want 0", t_addr[1]); end
    n_cmp++; if (t_addr[2] !== 18'h1) begin n_err++; $display("FAIL write addr_hi: got %h want 1", t_addr[2]); end
    n_cmp++; if (t_dq[1] !== 16'hBEEF) begin n_err++; $display("FAIL write dq_lo: got %h want beef", t_dq[1]); end
    n_cmp++; if (t_dq[2] !== 16'hDEAD) begin n_err++; $display("FAIL write dq_hi: got %h want dead", t_dq[2]); end
    n_cmp++; if (mem[0] !== 16'hBEEF) begin n_err++; $display("FAIL write mem0: got %h want beef", mem[0]); end
    n_cmp++; if (mem[1] !== 16'hDEAD) begin n_err++; $display("FAIL write mem1: got %h want dead", mem[1]); end
  endtask

  task automatic test_read();
    logic [0:5] e_rdy;
    e_rdy = 6'b000001;
    drive_en = 1'b1; probe = 1'b0;
    start_req(1'b0, 1'b1, 32'd1024, 32'h0);
    record(0, 6);
    drop_req();
    for (int i = 0; i < 6; i++) begin
      n_cmp++; if (t_ready[i] !== e_rdy[i]) begin n_err++; $display("FAIL read ready[%0d]: got %b want %b", i, t_ready[i], e_rdy[i]); end
      n_cmp++; if (t_we[i] !== 1'b1) begin n_err++; $display("FAIL read we_n[%0d]: got %b want 1", i, t_we[i]); end
    end
    n_cmp++; if (t_rd[5] !== 32'hDEADBEEF) begin n_err++; $display("FAIL read data: got %h want deadbeef", t_rd[5]); end
    drive_en = 1'b0;
  endtask

  task automatic test_addr_map();
    start_req(1'b1, 1'b0, 32'd1024 + 32'd4 * 32'd131071, 32'h0BADF00D);
    record(0, 6);
    drop_req();
    n_cmp++; if (t_addr[1] !== 18'h3FFFE) begin n_err++; $display("FAIL map top_lo: got %h want 3fffe", t_addr[1]); end
    n_cmp++; if (t_addr[2] !== 18'h3FFFF) begin n_err++; $display("FAIL map top_hi: got %h want 3ffff", t_addr[2]); end
    start_req(1'b1, 1'b0, 32'd1028, 32'h0BADF00D);
    record(0, 6);
    drop_req();
    n_cmp++; if (t_addr[1] !== 18'h2) begin n_err++; $display("FAIL map 1028_lo: got %h want 2", t_addr[1]); end
    n_cmp++; if (t_addr[2] !== 18'h3) begin n_err++; $display("FAIL map 1028_hi: got %h want 3", t_addr[2]); end
  endtask

  task automatic test_simultaneous();
    logic [0:5] e_rdy;
    logic [0:5] e_we;
    e_rdy = 6'b000001; e_we = 6'b100111;
    start_req(1'b1, 1'b1, 32'd1032, 32'h12345678);
    record(0, 6);
    drop_req();
    for (int i = 0; i < 6; i++) begin
      n_cmp++; if (t_ready[i] !== e_rdy[i]) begin n_err++; $display("FAIL simul ready[%0d]: got %b want %b", i, t_ready[i], e_rdy[i]); end
      n_cmp++; if (t_we[i] !== e_we[i]) begin n_err++; $display("FAIL simul we_n[%0d]: got %b want %b", i, t_we[i], e_we[i]); end
    end
    n_cmp++; if (t_rd[5] !== 32'hDEADBEEF) begin n_err++; $display("FAIL simul read_data_kept: got %h want deadbeef", t_rd[5]); end
    n_cmp++; if (mem[4] !== 16'h5678) begin n_err++; $display("FAIL simul mem4: got %h want 5678", mem[4]); end
    n_cmp++; if (mem[5] !== 16'h1234) begin n_err++; $display("FAIL simul mem5: got %h want 1234", mem[5]); end
  endtask

  task automatic test_back_to_back();
    logic [0:11] e_rdy;
    e_rdy = 12'b000001_000001;
    drive_en = 1'b1; probe = 1'b0;
    start_req(1'b0, 1'b1, 32'd1032, 32'h0);
    record(0, 12);
    drop_req();
    for (int i = 0; i < 12; i++) begin
      n_cmp++; if (t_ready[i] !== e_rdy[i]) begin n_err++; $display("FAIL b2b ready[%0d]: got %b want %b", i, t_ready[i], e_rdy[i]); end
    end
    n_cmp++; if (t_rd[5] !== 32'h12345678) begin n_err++; $display("FAIL b2b data_first: got %h want 12345678", t_rd[5]); end
    n_cmp++; if (t_rd[11] !== 32'h12345678) begin n_err++; $display("FAIL b2b data_second: got %h want 12345678", t_rd[11]); end
    n_cmp++; if (t_addr[7] !== 18'h4) begin n_err++; $display("FAIL b2b second_lo_addr: got %h want 4", t_addr[7]); end
    drive_en = 1'b0;
  endtask

  task automatic test_drop();
    logic [0:5] e_rdy;
    e_rdy = 6'b000001;
    drive_en = 1'b1; probe = 1'b0;
    start_req(1'b0, 1'b1, 32'd1024, 32'h0);
    record(0, 2);
    @(posedge clk); #1;
    bus.rd_en = 1'b0;
    record(2, 4);
    for (int i = 0; i < 6; i++) begin
      n_cmp++; if (t_ready[i] !== e_rdy[i]) begin n_err++; $display("FAIL drop ready[%0d]: got %b want %b", i, t_ready[i], e_rdy[i]); end
    end
    n_cmp++; if (t_rd[5] !== 32'hDEADBEEF) begin n_err++; $display("FAIL drop data: got %h want deadbeef", t_rd[5]); end
    @(negedge clk);
    n_cmp++; if (bus.ready !== 1'b1) begin n_err++; $display("FAIL drop idle_after: got %b want 1", bus.ready); end
    drive_en = 1'b0;
  endtask

  task automatic test_reset_mid_write();
    drive_en = 1'b1; probe = 1'b1;
    start_req(1'b1, 1'b0, 32'd1024, 32'hCAFEF00D);
    record(0, 3);
    n_cmp++; if (t_we[2] !== 1'b0) begin n_err++; $display("FAIL rstmid we_in_hi: got %b want 0", t_we[2]); end
    #1 rst = 1'b1;
    #1;
    n_cmp++; if (sram_we_n !== 1'b1) begin n_err++; $display("FAIL rstmid we_n: got %b want 1", sram_we_n); end
    n_cmp++; if (sram_dq !== 16'h0000) begin n_err++; $display("FAIL rstmid dq_released: got %h want 0000 probe", sram_dq); end
    n_cmp++; if (bus.read_data !== 32'h0) begin n_err++; $display("FAIL rstmid read_data: got %h want 00000000", bus.read_data); end
    n_cmp++; if (sram_addr !== 18'h0) begin n_err++; $display("FAIL rstmid sram_addr: got %h want 0", sram_addr); end
    n_cmp++; if (bus.ready !== 1'b0) begin n_err++; $display("FAIL rstmid ready_req_idle: got %b want 0", bus.ready); end
    bus.wr_en = 1'b0;
    #1;
    n_cmp++; if (bus.ready !== 1'b1) begin n_err++; $display("FAIL rstmid ready_idle: got %b want 1", bus.ready); end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.ready !== 1'b1) begin n_err++; $display("FAIL rstmid ready_after: got %b want 1", bus.ready); end
    n_cmp++; if (sram_we_n !== 1'b1) begin n_err++; $display("FAIL rstmid we_after: got %b want 1", sram_we_n); end
    drive_en = 1'b0; probe = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_idle();
    test_write();
    test_read();
    test_addr_map();
    test_simultaneous();
    test_back_to_back();
    test_drop();
    test_reset_mid_write();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/sram_controller.md
Name: sram_controller

Overview:
Sequences every data-memory access to the external 16-bit asynchronous SRAM on behalf of the MEM stage. Each 32-bit word access is split into two halfword cycles, then padded to a fixed latency. The block drives `ready` low while an access is in flight. The pipeline uses `~ready` as SRAM_freeze to stall the IF/ID/EX/MEM stage registers. Sits between the MEM stage and the SRAM pins.

Parameters:
ACCESS_CYCLES, 6, total cycles per access, counted from the request cycle through the cycle where `ready` is high; legal range >= 4
BASE_ADDR, 1024, byte address that maps to SRAM word 0

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
wr_en  input  1  write request from MEM stage, held during freeze
rd_en  input  1  read request from MEM stage, held during freeze
address  input  32  byte address, word aligned
write_data  input  32  store data
read_data  output  32  load data, valid when ready=1 after a read
ready  output  1  1 = no access pending or access completing this cycle; 0 = stall pipeline
SRAM_DQ  inout  16  SRAM data bus
SRAM_ADDR  output  18  SRAM halfword address
SRAM_WE_N  output  1  SRAM write enable, active low
SRAM_UB_N, SRAM_LB_N, SRAM_CE_N, SRAM_OE_N  output  1 each  tied 0

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous, active-high.
- Reset values:
  - state=IDLE, wait counter=0, read_data=0, latched op/addr/data=0.
  - SRAM_WE_N=1, SRAM_DQ=Z, SRAM_ADDR=0.
- Reset mid-access aborts immediately to IDLE with the values above. No partial write is retried.
- Address map:
  - idx = (address - BASE_ADDR)[18:2], 17 bits.
  - Low half goes to SRAM_ADDR={idx,0}; high half goes to {idx,1}.
  - address[1:0] is ignored.
- IDLE:
  - ready = ~(rd_en | wr_en).
  - On any request, latch op (write if wr_en, else read), idx and write_data, then go to LO.
  - Simultaneous rd_en & wr_en: write wins, and no read is performed.
- LO:
  - SRAM_ADDR={idx,0}.
  - Write: SRAM_WE_N=0, SRAM_DQ=wdata[15:0].
  - Read: SRAM_WE_N=1, SRAM_DQ=Z, and read_data[15:0] <= SRAM_DQ at the closing edge.
  - Then go to HI.
- HI:
  - Same as LO with {idx,1} and bits [31:16].
  - Then go to WAIT, or to DONE if ACCESS_CYCLES==4.
- WAIT:
  - SRAM_WE_N=1, SRAM_DQ=Z.
  - Stay ACCESS_CYCLES-4 cycles (counter zeroed on entry), then go to DONE.
- DONE: ready=1 for exactly one cycle, then go to IDLE unconditionally.
- ready in LO, HI and WAIT is 0.
- Default latency: request seen in IDLE at cycle 0. Cycles 0-4 have ready=0. Cycle 5 (DONE) has ready=1, and read_data holds the full word.
- Back-to-back: a request still asserted in the IDLE cycle after DONE starts a new access, with ready=0 in that cycle. The pipeline advances on the DONE edge, so the request seen then is the next instruction's.
- Request dropped mid-access: the access completes using the latched values; inputs are ignored outside IDLE.
- read_data changes only during read LO/HI. Writes leave it unchanged, and it holds between accesses.
- SRAM_DQ is driven only in write LO/HI; it is Z in every other state.

Test Plan:
- Write then read: wr_en with address=1024, write_data=0xDEADBEEF.
  - Required: SRAM_ADDR=0 with DQ=0xBEEF, then SRAM_ADDR=1 with DQ=0xDEAD, WE_N=0 in exactly those two cycles, ready=1 in cycle 5.
  - Then rd_en at the same address -> read_data=0xDEADBEEF when ready=1.
- Idle: no request -> ready=1 every cycle, WE_N=1, DQ=Z.
- Address map boundary: address=1024+4*131071 -> SRAM_ADDR 0x3FFFE then 0x3FFFF. Address 1028 -> SRAM_ADDR 2 then 3.
- Simultaneous wr_en and rd_en, write_data=0x12345678 -> write performed, read_data unchanged, ready pulses in cycle 5.
- Back-to-back: rd_en held high for 12 cycles -> ready pattern 000001 000001, two full accesses.
- Mid-access events:
  - rd_en dropped in cycle 2 -> access completes, ready=1 in cycle 5.
  - rst asserted in HI of a write -> WE_N=1 and DQ=Z immediately, state IDLE, read_data=0.
